// File: rtl/calc_sequencer.sv
// calc_sequencer: the calculator's user-level sequencer.
// It takes decoded key events (digit / operator / equals) and builds two
// unsigned decimal operands, a and b. It latches the operator, then computes
// a+b or a-b in a single cycle, or a*b with a shift-add multiplier that
// handles one bit of b per cycle, LSB first. The result is held for display
// and can be chained into the next operation.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   key_valid  in   one-cycle key event strobe
//   is_num     in   event is a digit
//   is_op      in   event is an operator
//   is_eq      in   event is equals
//   num_val    in   digit value 0-9 (values above 9 are ignored)
//   op_val     in   operator: 00 add, 01 sub, 10 mul, 11 clear
//   disp_val   out  value to display, RES_W two's complement, registered
//   op_active  out  currently latched operator
//   busy       out  high while a calculation is in progress
//   res_valid  out  one-cycle pulse when a result becomes available
//   err        out  high while the out-of-range error state is shown
module calc_sequencer #(
  parameter int DIGITS = 4,
  parameter int OP_W   = 14,
  parameter int RES_W  = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic             is_num,
  input  logic             is_op,
  input  logic             is_eq,
  input  logic [3:0]       num_val,
  input  logic [1:0]       op_val,
  output logic [RES_W-1:0] disp_val,
  output logic [1:0]       op_active,
  output logic             busy,
  output logic             res_valid,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_OP   = 3'd1,
    ST_B    = 3'd2,
    ST_CALC = 3'd3,
    ST_RES  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int STEP_W = $clog2(OP_W);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  // Largest result that can be carried forward as the next operand a.
  localparam logic [RES_W-1:0] MAX_RES = RES_W'(10**DIGITS - 1);

  state_t             state_r, state_s;
  logic [OP_W-1:0]    a_r, a_s, b_r, b_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [1:0]         op_r, op_s;
  logic [RES_W-1:0]   res_r, res_s;
  logic [RES_W-1:0]   mcand_r, mcand_s;   // multiplicand, shifted left per step
  logic [OP_W-1:0]    mplier_r, mplier_s; // copy of b consumed LSB first
  logic [STEP_W-1:0]  step_r, step_s;
  logic [RES_W-1:0]   disp_s;
  logic               digit_ev_s, op_ev_s, eq_ev_s, clear_ev_s;

  // Decimal append: v*10 + d built from shifts so no multiplier is needed.
  function automatic logic [OP_W-1:0] append_digit(input logic [OP_W-1:0] v,
                                                   input logic [3:0] d);
    return (v << 3) + (v << 1) + OP_W'(d);
  endfunction

  function automatic logic [RES_W-1:0] zext(input logic [OP_W-1:0] v);
    return {{(RES_W-OP_W){1'b0}}, v};
  endfunction

  // Key qualification: the event must have exactly one class flag set, and a digit must be 0-9.
  always_comb begin
    digit_ev_s = key_valid && is_num && !is_op && !is_eq && (num_val <= 4'd9);
    op_ev_s    = key_valid && is_op && !is_num && !is_eq;
    eq_ev_s    = key_valid && is_eq && !is_num && !is_op;
    clear_ev_s = op_ev_s && (op_val == OP_CLR);
  end

  // Next-state and datapath: the state transition table and the arithmetic.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    res_s    = res_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    step_s   = step_r;
    if (clear_ev_s) begin
      // Clear aborts from any state, including mid-calculation.
      state_s  = ST_A;
      a_s      = {OP_W{1'b0}};
      b_s      = {OP_W{1'b0}};
      cnt_s    = {CNT_W{1'b0}};
      op_s     = OP_ADD;
      res_s    = {RES_W{1'b0}};
      mcand_s  = {RES_W{1'b0}};
      mplier_s = {OP_W{1'b0}};
      step_s   = {STEP_W{1'b0}};
    end else begin
      case (state_r)
        ST_A: begin
          if (digit_ev_s) begin
            if (cnt_r < CNT_W'(DIGITS)) begin
              a_s   = append_digit(a_r, num_val);
              cnt_s = cnt_r + CNT_W'(1);
            end else begin
              a_s = a_r;
            end
          end else if (op_ev_s) begin
            op_s    = op_val;
            state_s = ST_OP;
          end else begin
            state_s = ST_A;
          end
        end
        ST_OP: begin
          if (digit_ev_s) begin
            b_s     = OP_W'(num_val);
            cnt_s   = CNT_W'(1);
            state_s = ST_B;
          end else if (op_ev_s) begin
            op_s = op_val;
          end else begin
            state_s = ST_OP;
          end
        end
        ST_B: begin
          if (digit_ev_s) begin
            if (cnt_r < CNT_W'(DIGITS)) begin
              b_s   = append_digit(b_r, num_val);
              cnt_s = cnt_r + CNT_W'(1);
            end else begin
              b_s = b_r;
            end
          end else if (eq_ev_s) begin
            state_s  = ST_CALC;
            res_s    = {RES_W{1'b0}};
            mcand_s  = zext(a_r);
            mplier_s = b_r;
            step_s   = {STEP_W{1'b0}};
          end else begin
            state_s = ST_B;
          end
        end
        ST_CALC: begin
          case (op_r)
            OP_ADD: begin
              res_s   = zext(a_r) + zext(b_r);
              state_s = ST_RES;
            end
            OP_SUB: begin
              res_s   = zext(a_r) - zext(b_r);
              state_s = ST_RES;
            end
            OP_MUL: begin
              if (mplier_r[0]) begin
                res_s = res_r + mcand_r;
              end else begin
                res_s = res_r;
              end
              mcand_s  = mcand_r << 1;
              mplier_s = mplier_r >> 1;
              step_s   = step_r + STEP_W'(1);
              if (step_r == STEP_W'(OP_W - 1)) begin
                state_s = ST_RES;
              end else begin
                state_s = ST_CALC;
              end
            end
            default: begin
              state_s = ST_RES;
            end
          endcase
        end
        ST_RES: begin
          if (digit_ev_s) begin
            a_s     = OP_W'(num_val);
            cnt_s   = CNT_W'(1);
            state_s = ST_A;
          end else if (op_ev_s) begin
            if (!res_r[RES_W-1] && (res_r <= MAX_RES)) begin
              a_s     = res_r[OP_W-1:0];
              op_s    = op_val;
              state_s = ST_OP;
            end else begin
              state_s = ST_ERR;
            end
          end else begin
            state_s = ST_RES;
          end
        end
        ST_ERR: begin
          if (digit_ev_s) begin
            a_s     = OP_W'(num_val);
            cnt_s   = CNT_W'(1);
            state_s = ST_A;
          end else begin
            state_s = ST_ERR;
          end
        end
        default: begin
          state_s = ST_A;
        end
      endcase
    end
  end

  // Display selection, based on the state and values that take effect at the next edge.
  always_comb begin
    case (state_s)
      ST_A, ST_OP:    disp_s = zext(a_s);
      ST_B, ST_CALC:  disp_s = zext(b_s);
      ST_RES:         disp_s = res_s;
      ST_ERR:         disp_s = {RES_W{1'b0}};
      default:        disp_s = {RES_W{1'b0}};
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_A;
      a_r       <= {OP_W{1'b0}};
      b_r       <= {OP_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= OP_ADD;
      res_r     <= {RES_W{1'b0}};
      mcand_r   <= {RES_W{1'b0}};
      mplier_r  <= {OP_W{1'b0}};
      step_r    <= {STEP_W{1'b0}};
      disp_val  <= {RES_W{1'b0}};
      busy      <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      res_r     <= res_s;
      mcand_r   <= mcand_s;
      mplier_r  <= mplier_s;
      step_r    <= step_s;
      disp_val  <= disp_s;
      busy      <= (state_s == ST_CALC);
      res_valid <= (state_r == ST_CALC) && (state_s == ST_RES);
      err       <= (state_s == ST_ERR);
    end
  end

  assign op_active = op_r;

endmodule
